hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Issue-side interlock that pairs with the EX-stage bypass network. It covers the hazards bypassing cannot:
//  - load-use: stall one cycle, then the bypass picks the value up from MEM/WB.
//  - multi-cycle DIV results: tracked by a register scoreboard.
//  - taken-branch flush.
//  Sits between ID and the pipeline-register enables (PC/IF-ID hold, ID/EX bubble, IF-ID flush).
// PARAMETERS
//  DIV_TIMEOUT  40  cycles DIV_WAIT may last before div_err is raised
//  CNT_W         6  width of the watchdog counter; must satisfy 2**CNT_W > DIV_TIMEOUT
// PORTS
//  clk           in   1  clock; all state updates on the rising edge
//  rst           in   1  synchronous reset, active-high
//  id_valid      in   1  ID holds a real instruction
//  id_rs1        in   5  ID source 1
//  id_rs2        in   5  ID source 2
//  id_rs1_used   in   1  instruction reads rs1
//  id_rs2_used   in   1  instruction reads rs2
//  id_is_div     in   1  ID instruction is DIV/DIVU/REM/REMU
//  ex_rd         in   5  EX destination
//  ex_mem_read   in   1  EX instruction is a load
//  ex_is_div     in   1  DIV enters the divider this cycle (EX)
//  div_done      in   1  divider result written back this cycle
//  br_taken      in   1  EX resolved a taken branch or jump
//  stall_if      out  1  hold PC and IF/ID
//  stall_id      out  1  hold ID
//  bubble_ex     out  1  load NOP into ID/EX
//  flush_id      out  1  clear IF/ID to NOP
//  div_busy      out  1  divider result outstanding
//  div_err       out  1  sticky watchdog error
// BEHAVIOUR
//  FSM states RUN, DIV_WAIT. Registered state: FSM, pend_rd[4:0], pend_v, wd_cnt, div_err.
//  Reset:
//  - FSM=RUN, pend_v=0, pend_rd=0, wd_cnt=0, div_err=0.
//  - While rst=1, every output is forced to 0.
//  src_hit(r) = id_valid && r!=0 && ((id_rs1_used && id_rs1==r) || (id_rs2_used && id_rs2==r)).
//  load_use = ex_mem_read && src_hit(ex_rd).
//  div_hz = pend_v && (src_hit(pend_rd) || (id_valid && id_is_div)).
//  Outputs (combinational, zero-latency, in priority order):
//  1 br_taken: flush_id=1, bubble_ex=1, stall_if=stall_id=0. Flush wins over any stall.
//  2 load_use || div_hz: stall_if=stall_id=bubble_ex=1, flush_id=0.
//  3 otherwise: all 0.
//  Load-use costs exactly one cycle: next cycle the load is in MEM, ex_mem_read=0 and the bypass resolves the operand.
//  div_busy=pend_v. div_err is a registered sticky bit, cleared only by rst.
//  Transitions:
//  - RUN->DIV_WAIT on ex_is_div: pend_rd<=ex_rd, pend_v<=(ex_rd!=0), wd_cnt<=0.
//    A DIV to x0 still enters DIV_WAIT, but pend_v=0, so only id_is_div is ...
//    (correction: no hazards are raised for it.)
//  - DIV_WAIT->RUN on div_done: pend_v<=0.
//  - DIV_WAIT: wd_cnt increments, saturating at 2**CNT_W-1. When wd_cnt==DIV_TIMEOUT, div_err<=1; state unchanged.
//  Simultaneous events:
//  - div_done && ex_is_div in the same cycle: the new DIV wins (reload pend_*, stay in DIV_WAIT). Cannot occur while div_hz stalls, but must be tolerated.
//  - br_taken while in DIV_WAIT: flush only; the DIV is older than the branch and must complete, so pend_* are retained.
//  - ex_is_div && br_taken in the same cycle: illegal (same EX slot). Checked by assertion only.
//  - rst mid-DIV_WAIT: returns to RUN and drops pend_v; a divider result arriving later is ignored.
// STRUCTURE
//  define.v gains: HZ_RUN/HZ_DIV_WAIT state encodings, NOP bubble constant.
//  One sub-module, hz_div_scoreboard: holds pend_rd, pend_v, wd_cnt, div_err; outputs src match.
//  The top level keeps the FSM and output priority.
// TESTING
//  1 lw x5; add x6,x5,x1 back-to-back -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then 0.
//  2 lw x0 followed by a use of x0; and lw x5 followed by an add whose rs2 is unused yet encodes 5 -> no stall.
//  3 div x7 issued; add x8,x7,x2 in ID -> stall holds until the div_done cycle; the add proceeds the next cycle.
//    Same test with div_done on cycle 3 vs cycle 33.
//  4 br_taken concurrent with load_use -> flush_id=1, bubble_ex=1, stall_if=0.
//  5 div pending; br_taken -> pend_v stays 1.
//    Then a second div in ID -> stalls until div_done.
//  6 ex_is_div, div_done never arrives -> div_err=1 at cycle DIV_TIMEOUT+1.
//    Assert rst for 1 cycle -> all outputs 0, FSM=RUN.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and helpers for the issue-side hazard interlock.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_DIV_WAIT = 1'b1
  } hz_state_e;

  // addi x0,x0,0: the instruction a bubbled ID/EX register represents.
  localparam logic [31:0] HZ_NOP_BUBBLE = 32'h0000_0013;

  // True when the instruction in ID really reads register r (x0 never counts).
  function automatic logic src_hit(
    input logic             valid,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             rs1_used,
    input logic             rs2_used,
    input logic [REG_W-1:0] r
  );
    return valid && (r != '0) &&
           ((rs1_used && (rs1 == r)) || (rs2_used && (rs2 == r)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_scoreboard.sv
// Single-entry DIV scoreboard: remembers the outstanding divide destination,
// matches it against ID sources, and runs the divider watchdog.
module hz_div_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [REG_W-1:0] i_load_rd,
  input  logic             i_clear,
  input  logic             i_wait,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  output logic             o_pend_v,
  output logic             o_pend_hit,
  output logic             o_div_err
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

  logic [REG_W-1:0] r_pend_rd;
  logic             r_pend_v;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_div_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_rd <= '0;
      r_pend_v  <= 1'b0;
      r_wd_cnt  <= '0;
      r_div_err <= 1'b0;
    end else begin
      if (i_load) begin
        r_pend_rd <= i_load_rd;
        r_pend_v  <= (i_load_rd != '0);
        r_wd_cnt  <= '0;
      end else if (i_clear) begin
        r_pend_v  <= 1'b0;
      end else if (i_wait && (r_wd_cnt != LP_CNT_MAX)) begin
        r_wd_cnt  <= r_wd_cnt + 1'b1;
      end
      // Sticky until reset: the divider is presumed hung.
      if (i_wait && (r_wd_cnt == LP_TIMEOUT)) begin
        r_div_err <= 1'b1;
      end
    end
  end

  assign o_pend_v   = r_pend_v;
  assign o_pend_hit = r_pend_v &&
                      src_hit(i_id_valid, i_id_rs1, i_id_rs2,
                              i_id_rs1_used, i_id_rs2_used, r_pend_rd);
  assign o_div_err  = r_div_err;

endmodule

// File: rtl/hazard_stall_unit.sv
// Issue-side interlock covering load-use, outstanding DIV results and
// taken-branch flush; drives the PC/IF-ID hold, ID/EX bubble and IF-ID flush.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       id_is_div,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_is_div,
  input  logic       div_done,
  input  logic       br_taken,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       div_busy,
  output logic       div_err
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;

  logic w_sb_clear;
  logic w_sb_wait;
  logic w_pend_v;
  logic w_pend_hit;
  logic w_div_err;
  logic w_load_use;
  logic w_div_hz;

  assign w_sb_wait  = (r_state == HZ_DIV_WAIT);
  // A new DIV in the same cycle as div_done reloads rather than clears.
  assign w_sb_clear = w_sb_wait && div_done && !ex_is_div;

  hz_div_scoreboard #(
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_div_sb (
    .clk           (clk),
    .rst           (rst),
    .i_load        (ex_is_div),
    .i_load_rd     (ex_rd),
    .i_clear       (w_sb_clear),
    .i_wait        (w_sb_wait),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rs1_used (id_rs1_used),
    .i_id_rs2_used (id_rs2_used),
    .o_pend_v      (w_pend_v),
    .o_pend_hit    (w_pend_hit),
    .o_div_err     (w_div_err)
  );

  assign w_load_use = ex_mem_read &&
                      src_hit(id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd);
  // Only one divider: a second DIV must also wait for the first to retire.
  assign w_div_hz   = w_pend_hit || (w_pend_v && id_valid && id_is_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN: begin
        if (ex_is_div) w_state_nxt = HZ_DIV_WAIT;
      end
      HZ_DIV_WAIT: begin
        if (!ex_is_div && div_done) w_state_nxt = HZ_RUN;
      end
      default: w_state_nxt = HZ_RUN;
    endcase
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    div_busy  = 1'b0;
    div_err   = 1'b0;
    if (!rst) begin
      div_busy = w_pend_v;
      div_err  = w_div_err;
      // Flush outranks stall: the wrong-path instruction in ID is discarded anyway.
      if (br_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (w_load_use || w_div_hz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  a_no_div_with_branch : assert property (@(posedge clk) disable iff (rst)
    !(ex_is_div && br_taken));

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a cycle-level reference model.
module tb_hazard_stall_unit;

  localparam int DIV_TIMEOUT = 40;
  localparam int CNT_W       = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_is_div;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_is_div, div_done, br_taken;
  logic       stall_if, stall_id, bubble_ex, flush_id, div_busy, div_err;

  int n_total = 0;
  int n_pass  = 0;

  hazard_stall_unit #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_is_div(id_is_div),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div),
    .div_done(div_done), .br_taken(br_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .div_busy(div_busy), .div_err(div_err)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding divide is "the register it will write,
  // and the edge at which it entered the divider".
  logic       m_wait = 1'b0;
  logic       m_pv   = 1'b0;
  logic [4:0] m_prd  = 5'd0;
  logic       m_err  = 1'b0;
  int         m_edge = 0;
  int         m_start = 0;
  logic [5:0] m_exp;

  function automatic logic reads(input logic [4:0] r);
    return id_valid && r != 5'd0 &&
           ((id_rs1_used && id_rs1 == r) || (id_rs2_used && id_rs2 == r));
  endfunction

  always @(posedge clk) begin
    m_edge <= m_edge + 1;
    if (rst) begin
      m_wait <= 1'b0; m_pv <= 1'b0; m_prd <= 5'd0; m_err <= 1'b0;
    end else begin
      if (m_wait && (m_edge - m_start) >= DIV_TIMEOUT + 1) m_err <= 1'b1;
      if (ex_is_div) begin
        m_wait <= 1'b1; m_pv <= (ex_rd != 5'd0); m_prd <= ex_rd; m_start <= m_edge;
      end else if (m_wait && div_done) begin
        m_wait <= 1'b0; m_pv <= 1'b0;
      end
    end
  end

  // Expected {stall_if, stall_id, bubble_ex, flush_id, div_busy, div_err}.
  always_comb begin
    m_exp = 6'b000000;
    if (!rst) begin
      m_exp[1:0] = {m_pv, m_err};
      if (br_taken)
        m_exp[5:2] = 4'b0011;
      else if ((ex_mem_read && reads(ex_rd)) ||
               (m_pv && (reads(m_prd) || (id_valid && id_is_div))))
        m_exp[5:2] = 4'b1110;
    end
  end

  wire [5:0] dut_out = {stall_if, stall_id, bubble_ex, flush_id, div_busy, div_err};

  always @(negedge clk) begin
    n_total = n_total + 1;
    if (dut_out === m_exp) n_pass = n_pass + 1;
    else $display("FAIL model_cycle t=%0t got=%b exp=%b", $time, dut_out, m_exp);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation for the current cycle, pinned on both DUT and model.
  task automatic lit(input string nm, input logic [5:0] exp);
    @(negedge clk);
    #1;
    n_total = n_total + 1;
    if (dut_out === exp) n_pass = n_pass + 1;
    else $display("FAIL %s dut got=%b exp=%b", nm, dut_out, exp);
    n_total = n_total + 1;
    if (m_exp === exp) n_pass = n_pass + 1;
    else $display("FAIL %s_model got=%b exp=%b", nm, m_exp, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic dv);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2; id_is_div = dv;
  endtask

  task automatic set_ex(input logic mr, input logic [4:0] rd, input logic dv,
                        input logic done, input logic br);
    ex_mem_read = mr; ex_rd = rd; ex_is_div = dv; div_done = done; br_taken = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0);
    set_ex(0, 0, 0, 0, 0);
  endtask

  task automatic div_stall_run(input string nm, input int done_cyc);
    set_ex(0, 5'd7, 1, 0, 0); set_id(0, 0, 0, 0, 0, 0);
    lit({nm, "_issue"}, 6'b000000);
    step();
    set_ex(0, 0, 0, 0, 0); set_id(1, 5'd7, 5'd2, 1, 1, 0);
    for (int c = 1; c <= done_cyc; c++) begin
      div_done = (c == done_cyc);
      if (c == 1 || c == done_cyc) lit({nm, "_stall"}, 6'b111010);
      step();
    end
    div_done = 1'b0;
    lit({nm, "_proceed"}, 6'b000000);
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    // Hazard-shaped inputs during reset must not leak onto the outputs.
    set_ex(1, 5'd5, 0, 0, 1); set_id(1, 5'd5, 5'd1, 1, 1, 0);
    lit("reset_outputs", 6'b000000);
    step();
    rst = 1'b0;
    idle();
    lit("post_reset_idle", 6'b000000);
    step();

    // lw x5 ; add x6,x5,x1
    set_ex(1, 5'd5, 0, 0, 0); set_id(1, 5'd5, 5'd1, 1, 1, 0);
    lit("load_use", 6'b111000);
    step();
    set_ex(0, 5'd0, 0, 0, 0);
    lit("load_use_one_cycle", 6'b000000);
    step();

    // lw x0 ; use of x0
    set_ex(1, 5'd0, 0, 0, 0); set_id(1, 5'd0, 5'd0, 1, 1, 0);
    lit("load_x0", 6'b000000);
    step();
    // lw x5 ; rs2 field encodes 5 but is unused
    set_ex(1, 5'd5, 0, 0, 0); set_id(1, 5'd1, 5'd5, 1, 0, 0);
    lit("rs2_unused", 6'b000000);
    step();
    // rs2 really used
    set_id(1, 5'd1, 5'd5, 1, 1, 0);
    lit("load_use_rs2", 6'b111000);
    step();
    // load hit but ID empty
    set_id(0, 5'd5, 5'd5, 1, 1, 0);
    lit("load_id_invalid", 6'b000000);
    step();
    idle();
    step();

    div_stall_run("div_done3", 3);
    div_stall_run("div_done33", 33);

    // Branch concurrent with load-use: flush wins.
    set_ex(1, 5'd5, 0, 0, 1); set_id(1, 5'd5, 5'd1, 1, 1, 0);
    lit("branch_over_load_use", 6'b001100);
    step();
    idle();
    step();

    // DIV to x0: no busy, no hazards; retire it.
    set_ex(0, 5'd0, 1, 0, 0);
    step();
    set_ex(0, 0, 0, 0, 0); set_id(1, 5'd0, 5'd0, 1, 1, 1);
    lit("div_x0_no_hazard", 6'b000000);
    step();
    div_done = 1'b1;
    step();
    idle();
    step();

    // div x9 pending, then a taken branch keeps it pending.
    set_ex(0, 5'd9, 1, 0, 0);
    step();
    set_ex(0, 0, 0, 0, 1); set_id(1, 5'd9, 5'd0, 1, 0, 0);
    lit("branch_during_div", 6'b001110);
    step();
    set_ex(0, 0, 0, 0, 0); set_id(1, 5'd3, 5'd4, 1, 1, 1);
    lit("second_div_stall", 6'b111010);
    step();
    step();
    div_done = 1'b1;
    lit("second_div_done_cycle", 6'b111010);
    step();
    div_done = 1'b0;
    lit("second_div_proceeds", 6'b000000);
    step();

    // New DIV collides with div_done of the old one: new one wins.
    idle();
    set_ex(0, 5'd12, 1, 0, 0);
    step();
    set_ex(0, 5'd10, 1, 1, 0);
    lit("div_reload_same_cycle", 6'b000010);
    step();
    set_ex(0, 0, 0, 0, 0); set_id(1, 5'd12, 5'd10, 0, 1, 0);
    lit("reloaded_rd_stalls", 6'b111010);
    step();
    set_id(1, 5'd12, 5'd0, 1, 0, 0);
    lit("old_rd_released", 6'b000010);
    step();
    div_done = 1'b1;
    step();
    idle();
    step();

    // Watchdog: div_done never arrives.
    set_ex(0, 5'd11, 1, 0, 0);
    step();
    idle();
    for (int j = 1; j <= DIV_TIMEOUT + 1; j++) begin
      step();
      if (j == DIV_TIMEOUT)     lit("wd_before_timeout", 6'b000010);
      if (j == DIV_TIMEOUT + 1) lit("wd_timeout", 6'b000011);
    end
    step();
    lit("wd_sticky", 6'b000011);
    rst = 1'b1;
    set_id(1, 5'd11, 5'd0, 1, 0, 0);
    lit("rst_mid_wait", 6'b000000);
    step();
    rst = 1'b0;
    lit("after_rst_pend_dropped", 6'b000000);
    step();
    idle();
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    // Back in RUN: the watchdog must stay quiet indefinitely.
    for (int j = 0; j < DIV_TIMEOUT + 5; j++) step();
    lit("run_no_watchdog", 6'b000000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
